// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Moore control FSM for the multicycle core. It sequences the single-ported
// memory, the register file and the ALU for four instruction classes:
// R-format, ld, sd and beq. One memory request is outstanding at a time and
// each request waits on mem_ready. A one-cycle retire strobe marks the end
// of every completed instruction.
//
// Handshake: mem_req (with exactly one of MemRead/MemWrite) is valid and held
// stable until the cycle in which mem_ready is high. That cycle completes the
// request. mem_ready in any cycle without mem_req is ignored. The FSM always
// leaves the memory state on completion, so a new request can never start in
// the same cycle as the previous mem_ready.
//
// Optional build macro: ILLEGAL_TRAP_EN
//   defined   - an unknown opcode in DECODE sets the sticky error flag and
//               parks the FSM in IDLE.
//   undefined - an unknown opcode is a NOP (back to FETCH, no retire), and
//               only a memory timeout sets error.
//
// Parameters
//   ALUOP_WIDTH   width of ALUOp (00 add, 01 sub/compare, 10 funct-decoded)
//   OPCODE_WIDTH  width of the opcode field
//   MAX_WAIT      wait cycles tolerated before a memory timeout
//
// Ports
//   clk, reset    rising-edge clock, synchronous active-high reset
//   run           level; the FSM leaves IDLE only while high
//   opcode        IR[6:0], decoded in DECODE, held stable through the instr
//   zero          ALU zero flag (qualifies PCWriteCond in the datapath)
//   mem_ready     memory completes the current request this cycle
//   mem_req       memory request valid
//   MemRead       read strobe (with mem_req)
//   MemWrite      write strobe (with mem_req)
//   IRWrite       load IR from memory data
//   PCWrite       unconditional PC update (PC+4)
//   PCWriteCond   PC <- branch target when zero=1
//   ALUSrcA       0=PC, 1=rs1
//   ALUSrcB       00=rs2, 01=const 4, 10=imm
//   ALUOp         ALU operation class
//   MemtoReg      write-back selects memory data
//   RegWrite      register file write enable
//   retire        one-cycle pulse at instruction completion
//   error         sticky; cleared only by reset
//   state_dbg     current FSM state encoding, for observation only
// -----------------------------------------------------------------------------
module multicycle_control #(
    parameter int ALUOP_WIDTH  = 2,
    parameter int OPCODE_WIDTH = 7,
    parameter int MAX_WAIT     = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    run,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic                    zero,
    input  logic                    mem_ready,
    output logic                    mem_req,
    output logic                    MemRead,
    output logic                    MemWrite,
    output logic                    IRWrite,
    output logic                    PCWrite,
    output logic                    PCWriteCond,
    output logic                    ALUSrcA,
    output logic [1:0]              ALUSrcB,
    output logic [ALUOP_WIDTH-1:0]  ALUOp,
    output logic                    MemtoReg,
    output logic                    RegWrite,
    output logic                    retire,
    output logic                    error,
    output logic [3:0]              state_dbg
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    // State encoding
    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_EXEC_R = 4'd3;
    localparam logic [3:0] S_WB_R   = 4'd4;
    localparam logic [3:0] S_ADDR   = 4'd5;
    localparam logic [3:0] S_MEM_LD = 4'd6;
    localparam logic [3:0] S_WB_LD  = 4'd7;
    localparam logic [3:0] S_MEM_SD = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;

    // Supported opcodes
    localparam logic [OPCODE_WIDTH-1:0] OP_R   = OPCODE_WIDTH'(7'b0110011);
    localparam logic [OPCODE_WIDTH-1:0] OP_LD  = OPCODE_WIDTH'(7'b0000011);
    localparam logic [OPCODE_WIDTH-1:0] OP_SD  = OPCODE_WIDTH'(7'b0100011);
    localparam logic [OPCODE_WIDTH-1:0] OP_BEQ = OPCODE_WIDTH'(7'b1100011);

    // ALU operation classes
    localparam logic [ALUOP_WIDTH-1:0] ALU_ADD   = ALUOP_WIDTH'(2'b00);
    localparam logic [ALUOP_WIDTH-1:0] ALU_SUB   = ALUOP_WIDTH'(2'b01);
    localparam logic [ALUOP_WIDTH-1:0] ALU_FUNCT = ALUOP_WIDTH'(2'b10);

    // ALU operand B selects
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    logic [3:0]        state;
    logic [3:0]        state_nx;
    logic [WAIT_W-1:0] wait_cnt;
    logic              error_q;
    logic              mem_wait;
    logic              timeout;
    logic              illegal_op;
    logic              set_error;

    // -------------------------------------------------------------------------
    // Output decode: a function of state only, except the completion-cycle
    // strobes (IRWrite/PCWrite in FETCH, retire in MEM_SD) that qualify on
    // mem_ready.
    // -------------------------------------------------------------------------
    always_comb begin
        mem_req     = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_RS2;
        ALUOp       = ALU_ADD;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        retire      = 1'b0;
        case (state)
            S_FETCH: begin
                // ALU computes PC+4 while the instruction is read.
                mem_req = 1'b1;
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                // Branch target precomputed as PC + imm.
                ALUSrcB = SRCB_IMM;
            end
            S_EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALU_FUNCT;
            end
            S_WB_R: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
            end
            S_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEM_LD: begin
                mem_req = 1'b1;
                MemRead = 1'b1;
            end
            S_WB_LD: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                retire   = 1'b1;
            end
            S_MEM_SD: begin
                mem_req  = 1'b1;
                MemWrite = 1'b1;
                retire   = mem_ready;
            end
            S_BRANCH: begin
                // Compare rs1 - rs2; the datapath gates PCWriteCond with zero.
                ALUSrcA     = 1'b1;
                ALUOp       = ALU_SUB;
                PCWriteCond = 1'b1;
                retire      = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // A request cycle without completion; the last permitted one times out.
    assign mem_wait = mem_req & ~mem_ready;
    assign timeout  = mem_wait & (wait_cnt == WAIT_LAST);

    always_comb begin
        illegal_op = 1'b1;
        case (opcode)
            OP_R, OP_LD, OP_SD, OP_BEQ: illegal_op = 1'b0;
            default:                    illegal_op = 1'b1;
        endcase
    end

`ifdef ILLEGAL_TRAP_EN
    assign set_error = timeout | ((state == S_DECODE) & illegal_op);
`else
    assign set_error = timeout;
`endif

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                // A sticky error parks the FSM here until reset.
                if (run && !error_q) state_nx = S_FETCH;
            end
            S_FETCH: begin
                if (mem_ready)    state_nx = S_DECODE;
                else if (timeout) state_nx = S_IDLE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_R:         state_nx = S_EXEC_R;
                    OP_LD, OP_SD: state_nx = S_ADDR;
                    OP_BEQ:       state_nx = S_BRANCH;
`ifdef ILLEGAL_TRAP_EN
                    default:      state_nx = S_IDLE;
`else
                    default:      state_nx = S_FETCH;
`endif
                endcase
            end
            S_EXEC_R: state_nx = S_WB_R;
            S_ADDR: begin
                // IR still holds the opcode decoded in DECODE.
                state_nx = (opcode == OP_SD) ? S_MEM_SD : S_MEM_LD;
            end
            S_MEM_LD: begin
                if (mem_ready)    state_nx = S_WB_LD;
                else if (timeout) state_nx = S_IDLE;
            end
            S_MEM_SD: begin
                if (mem_ready)    state_nx = run ? S_FETCH : S_IDLE;
                else if (timeout) state_nx = S_IDLE;
            end
            S_WB_R, S_WB_LD, S_BRANCH: begin
                // Instruction boundary: continue only while run is high.
                state_nx = run ? S_FETCH : S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State, wait counter and sticky error
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            error_q  <= 1'b0;
        end else begin
            state <= state_nx;
            if (set_error) error_q <= 1'b1;
            // Any cycle that is not a pending wait leaves the counter at zero,
            // so every memory state is entered with a cleared count.
            if (mem_wait && !timeout) wait_cnt <= wait_cnt + 1'b1;
            else                      wait_cnt <= '0;
        end
    end

    assign error     = error_q;
    assign state_dbg = state;

endmodule
